// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: format codes, the R-type
// opcode (same value the core's control decoder uses), loader state encodings
// and the field-level request payload.
package instr_loader_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_BAD = 2'b11;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_req_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational MIPS field packer.
//   req       : field-level request (format selects which fields are used)
//   word_c    : packed 32-bit instruction word (0 for an illegal format)
//   illegal_c : high when the format code is the reserved value
module instr_encode
    import instr_loader_pkg::*;
(
    input  instr_req_t        req,
    output logic [WORD_W-1:0] word_c,
    output logic              illegal_c
);

    always_comb begin
        word_c    = '0;
        illegal_c = 1'b0;
        case (req.fmt)
            // R-type always carries the R-type opcode regardless of the request.
            FMT_R:   word_c = {OPCODE_RTYPE, req.rs, req.rt, req.rd, req.shamt, req.func};
            FMT_I:   word_c = {req.opcode, req.rs, req.rt, req.imm};
            FMT_J:   word_c = {req.opcode, req.target};
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader: accepts field-level instruction requests, encodes them and
// writes them sequentially into instruction memory while stalling the core.
//   clk, reset           : clock, synchronous active-high reset
//   start, finish        : open / close a load session
//   in_valid, in_ready   : request handshake; fmt..target are the fields
//   imem_we/addr/wdata   : instruction-memory write port (one-entry write stage)
//   cpu_hold             : core stall, high from start until the session is done
//   count, done, err     : words written, session complete, sticky error
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            func,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  imem_we,
    output logic [DEPTH_LOG2-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_hold,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0]      CAPACITY = CNT_W'(1) << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] BASE_PTR = DEPTH_LOG2'(BASE_ADDR);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  in_ready_q, in_ready_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    instr_req_t        req_c;
    logic [WORD_W-1:0] word_c;
    logic              illegal_c;
    logic              accept_c;

    assign req_c = '{fmt: fmt, opcode: opcode, rs: rs, rt: rt, rd: rd,
                     shamt: shamt, func: func, imm: imm, target: target};

    instr_encode u_encode (
        .req       (req_c),
        .word_c    (word_c),
        .illegal_c (illegal_c)
    );

    assign accept_c = in_valid && in_ready_q;

    // Next-state, write stage, pointer and counter update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;

        // The entry in the write stage is written this cycle and retires at the edge.
        if (we_q) begin
            ptr_d   = ptr_q + DEPTH_LOG2'(1);
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    acc_d   = '0;
                    count_d = '0;
                    ptr_d   = BASE_PTR;
                end
            end
            ST_LOAD: begin
                if (accept_c) begin
                    if (illegal_c) begin
                        state_d = ST_ERR;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = word_c;
                        acc_d   = acc_q + CNT_W'(1);
                        if (finish) state_d = ST_DRAIN;
                    end
                end else if (in_valid && (acc_q == CAPACITY)) begin
                    state_d = ST_ERR;
                end else if (finish) begin
                    state_d = ST_DRAIN;
                end
            end
            // Any pending write is in flight during this cycle.
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD) && (acc_d < CAPACITY);
        cpu_hold_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN) || (state_d == ST_ERR);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            ptr_q      <= BASE_PTR;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // A write pending when reset arrives is suppressed in the reset cycle itself.
    assign imem_we    = we_q && !reset;
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign in_ready   = in_ready_q;
    assign cpu_hold   = cpu_hold_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
